// File: rtl/cpu_fpu_issue.sv
// FPU issue stage: queues FP commands and drives the four-phase request/ready
// handshake to a multi-cycle unit, returning results in order with their tags.
module cpu_fpu_issue #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_accept,
    input  logic [31:0]      i_op1,
    input  logic [31:0]      i_op2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_unit_request,
    output logic [31:0]      o_unit_op1,
    output logic [31:0]      o_unit_op2,
    input  logic             i_unit_ready,
    input  logic [31:0]      i_unit_result,
    output logic             o_result_valid,
    output logic [31:0]      o_result,
    output logic [TAG_W-1:0] o_result_tag,
    output logic             o_timeout,
    output logic             o_idle
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic             TMO_EN   = (TIMEOUT != 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQUEST,
        S_RELEASE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      fifo_op1_q [DEPTH];
    logic [31:0]      fifo_op1_d [DEPTH];
    logic [31:0]      fifo_op2_q [DEPTH];
    logic [31:0]      fifo_op2_d [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [DEPTH];
    logic [TAG_W-1:0] fifo_tag_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             unit_req_q, unit_req_d;
    logic [31:0]      unit_op1_q, unit_op1_d;
    logic [31:0]      unit_op2_q, unit_op2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      result_q, result_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             timeout_q, timeout_d;

    logic accept;
    logic push;
    logic pop;

    assign accept = (count_q < CNT_W'(DEPTH));
    assign push   = i_valid && accept;
    assign pop    = (state_q == S_IDLE) && (count_q != '0);

    always_comb begin
        fifo_op1_d  = fifo_op1_q;
        fifo_op2_d  = fifo_op2_q;
        fifo_tag_d  = fifo_tag_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        unit_req_d  = unit_req_q;
        unit_op1_d  = unit_op1_q;
        unit_op2_d  = unit_op2_q;
        tag_d       = tag_q;
        timer_d     = timer_q;
        res_valid_d = 1'b0;
        result_d    = result_q;
        res_tag_d   = res_tag_q;
        timeout_d   = 1'b0;

        if (push) begin
            fifo_op1_d[wr_ptr_q] = i_op1;
            fifo_op2_d[wr_ptr_q] = i_op2;
            fifo_tag_d[wr_ptr_q] = i_tag;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    unit_op1_d = fifo_op1_q[rd_ptr_q];
                    unit_op2_d = fifo_op2_q[rd_ptr_q];
                    tag_d      = fifo_tag_q[rd_ptr_q];
                    unit_req_d = 1'b1;
                    timer_d    = '0;
                    state_d    = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (i_unit_ready) begin
                    result_d    = i_unit_result;
                    res_tag_d   = tag_q;
                    res_valid_d = 1'b1;
                    unit_req_d  = 1'b0;
                    state_d     = S_RELEASE;
                end else if (TMO_EN && (timer_q == TMR_LAST)) begin
                    // Abort on the TIMEOUT-th request cycle; a quiet NaN stands in for the result.
                    result_d    = QNAN;
                    res_tag_d   = tag_q;
                    res_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    unit_req_d  = 1'b0;
                    state_d     = S_RELEASE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!i_unit_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            fifo_op1_q  <= '{default: '0};
            fifo_op2_q  <= '{default: '0};
            fifo_tag_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            unit_req_q  <= 1'b0;
            unit_op1_q  <= '0;
            unit_op2_q  <= '0;
            tag_q       <= '0;
            timer_q     <= '0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            res_tag_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fifo_op1_q  <= fifo_op1_d;
            fifo_op2_q  <= fifo_op2_d;
            fifo_tag_q  <= fifo_tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            unit_req_q  <= unit_req_d;
            unit_op1_q  <= unit_op1_d;
            unit_op2_q  <= unit_op2_d;
            tag_q       <= tag_d;
            timer_q     <= timer_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
            res_tag_q   <= res_tag_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_accept       = accept;
    assign o_unit_request = unit_req_q;
    assign o_unit_op1     = unit_op1_q;
    assign o_unit_op2     = unit_op2_q;
    assign o_result_valid = res_valid_q;
    assign o_result       = result_q;
    assign o_result_tag   = res_tag_q;
    assign o_timeout      = timeout_q;
    assign o_idle         = (state_q == S_IDLE) && (count_q == '0) && !unit_req_q;

endmodule

// File: tb/tb_cpu_fpu_issue.sv
// Scoreboard bench for cpu_fpu_issue with a registered FPU-adder responder model.
module tb_cpu_fpu_issue;

    logic        i_clock;
    logic        i_reset;
    logic        i_valid;
    logic        o_accept;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic [4:0]  i_tag;
    logic        o_unit_request;
    logic [31:0] o_unit_op1;
    logic [31:0] o_unit_op2;
    logic        i_unit_ready;
    logic [31:0] i_unit_result;
    logic        o_result_valid;
    logic [31:0] o_result;
    logic [4:0]  o_result_tag;
    logic        o_timeout;
    logic        o_idle;

    cpu_fpu_issue #(
        .DEPTH  (2),
        .TAG_W  (5),
        .TIMEOUT(8)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .o_accept      (o_accept),
        .i_op1         (i_op1),
        .i_op2         (i_op2),
        .i_tag         (i_tag),
        .o_unit_request(o_unit_request),
        .o_unit_op1    (o_unit_op1),
        .o_unit_op2    (o_unit_op2),
        .i_unit_ready  (i_unit_ready),
        .i_unit_result (i_unit_result),
        .o_result_valid(o_result_valid),
        .o_result      (o_result),
        .o_result_tag  (o_result_tag),
        .o_timeout     (o_timeout),
        .o_idle        (o_idle)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mode   = 0;   // 0 normal adder, 1 never ready, 2 ready held 3 extra cycles
    int   lat    = 2;

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Hand-computed single-precision sums for the operand pairs used below.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F80_0000, 32'h4000_0000}: fadd = 32'h4040_0000;
            {32'h3FC0_0000, 32'hBFC0_0000}: fadd = 32'h0000_0000;
            {32'h4040_0000, 32'h3F80_0000}: fadd = 32'h4080_0000;
            {32'h3F80_0000, 32'h3F80_0000}: fadd = 32'h4000_0000;
            {32'h4000_0000, 32'h4000_0000}: fadd = 32'h4080_0000;
            {32'h4080_0000, 32'h4080_0000}: fadd = 32'h4100_0000;
            {32'h40A0_0000, 32'h3F80_0000}: fadd = 32'h40C0_0000;
            {32'h4100_0000, 32'h4100_0000}: fadd = 32'h4180_0000;
            {32'h3F00_0000, 32'h3F00_0000}: fadd = 32'h3F80_0000;
            default:                        fadd = 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder: samples request/operands mid-cycle, updates ready/result after the edge.
    initial begin : responder
        logic        req_s;
        logic        rst_s;
        logic [31:0] a_s;
        logic [31:0] b_s;
        int          busy;
        int          hold;
        busy = 0;
        hold = 0;
        forever begin
            @(negedge i_clock);
            req_s = o_unit_request;
            rst_s = i_reset;
            a_s   = o_unit_op1;
            b_s   = o_unit_op2;
            @(posedge i_clock);
            #1;
            if (rst_s) begin
                i_unit_ready = 1'b0;
                busy         = 0;
                hold         = 0;
            end else if (i_unit_ready) begin
                if (req_s) i_unit_result = 32'hBAD0_BAD0;
                else if (hold > 0) hold--;
                else i_unit_ready = 1'b0;
            end else if (req_s && mode != 1) begin
                busy++;
                if (busy >= lat) begin
                    i_unit_ready  = 1'b1;
                    i_unit_result = fadd(a_s, b_s);
                    busy          = 0;
                    hold          = (mode == 2) ? 3 : 0;
                end
            end
        end
    end

    initial begin : monitor
        logic        prev_req;
        logic [31:0] prev_op1;
        logic [31:0] prev_op2;
        exp_t        e;
        prev_req = 1'b0;
        prev_op1 = '0;
        prev_op2 = '0;
        forever begin
            @(negedge i_clock);
            if (o_result_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h tag %0d, none expected", o_result, o_result_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", o_result, e.res);
                    chk("result_tag", {27'd0, o_result_tag}, {27'd0, e.tag});
                    chk("timeout_flag", {31'd0, o_timeout}, {31'd0, e.to});
                end
            end else if (o_timeout) begin
                checks++;
                errors++;
                $display("FAIL lone_timeout: got o_timeout=1 expected 0 without o_result_valid");
            end
            if (o_unit_request && !prev_req)
                chk("ready_low_at_request", {31'd0, i_unit_ready}, 32'd0);
            if (o_unit_request && prev_req) begin
                chk("op1_stable", o_unit_op1, prev_op1);
                chk("op2_stable", o_unit_op2, prev_op2);
            end
            prev_req = o_unit_request && !i_reset;
            prev_op1 = o_unit_op1;
            prev_op2 = o_unit_op2;
        end
    end

    // Called just after a clock edge; holds i_valid until the command is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                        input logic [31:0] er, input logic eto, output logic waited);
        int n;
        exp_t e;
        n      = 0;
        waited = 1'b0;
        i_valid = 1'b1;
        i_op1   = a;
        i_op2   = b;
        i_tag   = t;
        while (!o_accept && n < 200) begin
            waited = 1'b1;
            @(posedge i_clock);
            #1;
            n++;
        end
        if (!o_accept) chk("accept_wait", {31'd0, o_accept}, 32'd1);
        e.res = er;
        e.tag = t;
        e.to  = eto;
        exp_q.push_back(e);
        @(posedge i_clock);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge i_clock);
            #1;
            n++;
        end while (!(o_idle && exp_q.size() == 0) && n < 200);
        chk({name, "_idle"}, {31'd0, o_idle}, 32'd1);
        chk({name, "_drained"}, exp_q.size(), 32'd0);
        chk({name, "_req_low"}, {31'd0, o_unit_request}, 32'd0);
    endtask

    initial begin : stimulus
        logic w1, w2, w3;
        int   n;
        i_reset       = 1'b1;
        i_valid       = 1'b0;
        i_op1         = '0;
        i_op2         = '0;
        i_tag         = '0;
        i_unit_ready  = 1'b0;
        i_unit_result = '0;
        repeat (2) @(posedge i_clock);
        #1;
        chk("rst_request", {31'd0, o_unit_request}, 32'd0);
        chk("rst_valid", {31'd0, o_result_valid}, 32'd0);
        chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_op1", o_unit_op1, 32'd0);
        chk("rst_accept", {31'd0, o_accept}, 32'd1);
        chk("rst_idle", {31'd0, o_idle}, 32'd1);
        i_reset = 1'b0;
        @(posedge i_clock);
        #1;

        // Single add, with one-cycle issue latency.
        send(32'h3F80_0000, 32'h4000_0000, 5'd3, 32'h4040_0000, 1'b0, w1);
        chk("req_before_issue", {31'd0, o_unit_request}, 32'd0);
        @(posedge i_clock);
        #1;
        chk("req_after_issue", {31'd0, o_unit_request}, 32'd1);
        chk("issue_op1", o_unit_op1, 32'h3F80_0000);
        chk("issue_op2", o_unit_op2, 32'h4000_0000);
        wait_idle("single");

        // Back-to-back commands.
        send(32'h3FC0_0000, 32'hBFC0_0000, 5'd1, 32'h0000_0000, 1'b0, w1);
        send(32'h4040_0000, 32'h3F80_0000, 5'd2, 32'h4080_0000, 1'b0, w2);
        wait_idle("b2b");

        // FIFO fills while the unit is busy.
        lat = 6;
        send(32'h3F80_0000, 32'h3F80_0000, 5'd4, 32'h4000_0000, 1'b0, w1);
        @(posedge i_clock);
        #1;
        chk("busy_req", {31'd0, o_unit_request}, 32'd1);
        send(32'h4000_0000, 32'h4000_0000, 5'd5, 32'h4080_0000, 1'b0, w1);
        send(32'h4080_0000, 32'h4080_0000, 5'd6, 32'h4100_0000, 1'b0, w2);
        chk("accept_full", {31'd0, o_accept}, 32'd0);
        send(32'h40A0_0000, 32'h3F80_0000, 5'd9, 32'h40C0_0000, 1'b0, w3);
        chk("fill_wait1", {31'd0, w1}, 32'd0);
        chk("fill_wait2", {31'd0, w2}, 32'd0);
        chk("fill_wait3", {31'd0, w3}, 32'd1);
        wait_idle("fill");
        lat = 2;

        // Stuck unit: abort after 8 request cycles, then the queued command issues.
        mode = 1;
        send(32'h4100_0000, 32'h4100_0000, 5'd10, 32'h7FC0_0000, 1'b1, w1);
        send(32'h3F00_0000, 32'h3F00_0000, 5'd11, 32'h3F80_0000, 1'b0, w2);
        n = 0;
        do begin
            @(negedge i_clock);
            if (o_unit_request) n++;
        end while (o_unit_request && n < 50);
        chk("timeout_cycles", n, 32'd8);
        mode = 0;
        wait_idle("timeout");

        // Ready held high after request drops.
        mode = 2;
        send(32'h3F80_0000, 32'h4000_0000, 5'd12, 32'h4040_0000, 1'b0, w1);
        send(32'h4000_0000, 32'h4000_0000, 5'd13, 32'h4080_0000, 1'b0, w2);
        wait_idle("hold");
        mode = 0;

        // Reset mid-request with one command queued.
        lat = 6;
        send(32'h4000_0000, 32'h4000_0000, 5'd14, 32'h4080_0000, 1'b0, w1);
        send(32'h3F80_0000, 32'h3F80_0000, 5'd15, 32'h4000_0000, 1'b0, w2);
        chk("pre_reset_req", {31'd0, o_unit_request}, 32'd1);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
        chk("mid_rst_req", {31'd0, o_unit_request}, 32'd0);
        chk("mid_rst_valid", {31'd0, o_result_valid}, 32'd0);
        chk("mid_rst_idle", {31'd0, o_idle}, 32'd1);
        chk("mid_rst_accept", {31'd0, o_accept}, 32'd1);
        exp_q.delete();
        i_reset = 1'b0;
        repeat (12) @(posedge i_clock);
        #1;
        chk("post_rst_quiet", {31'd0, o_unit_request}, 32'd0);
        lat = 2;
        send(32'h4080_0000, 32'h4080_0000, 5'd16, 32'h4100_0000, 1'b0, w1);
        wait_idle("post_reset");

        repeat (3) @(posedge i_clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
